// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared constants and helpers for the LED comet-tail fader
package led_pkg;

  localparam int DEFAULT_DECAY_TICKS = 50000;
  localparam int DEFAULT_DECAY_STEP  = 4;

  function automatic int bright_max(input int w);
    return (1 << w) - 1;
  endfunction

  // Saturating decrement: fading never wraps back to full brightness.
  function automatic int sat_dec(input int b, input int step);
    return (b > step) ? b - step : 0;
  endfunction

endpackage

// File: rtl/fade_channel.sv
// rtl/fade_channel.sv - one LED channel: brightness register, update priority, PWM compare
module fade_channel
  import led_pkg::*;
#(
  parameter int BRIGHT_W   = 8,
  parameter int PWM_W      = 8,
  parameter int DECAY_STEP = DEFAULT_DECAY_STEP
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                set,
  input  logic                decay_tick,
  input  logic [PWM_W-1:0]    pwm_cnt,
  output logic                led,
  output logic [BRIGHT_W-1:0] bright
);

  localparam logic [BRIGHT_W-1:0] MAX = BRIGHT_W'(bright_max(BRIGHT_W));

  logic [BRIGHT_W-1:0] b;
  int                  dec;

  always_comb begin
    dec = sat_dec(int'(b), DECAY_STEP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b   <= '0;
      led <= 1'b0;
    end else begin
      led <= enable & (set | (pwm_cnt < b[BRIGHT_W-1 -: PWM_W]));
      if (enable) begin
        // A lit pattern bit wins over a decay landing in the same cycle.
        if (set)
          b <= MAX;
        else if (decay_tick)
          b <= BRIGHT_W'(dec);
      end
    end
  end

  assign bright = b;

endmodule

// File: rtl/led_fader.sv
// rtl/led_fader.sv - fades cleared LED pattern bits out through per-channel PWM
module led_fader
  import led_pkg::*;
#(
  parameter int CHANNELS    = 8,
  parameter int BRIGHT_W    = 8,
  parameter int PWM_W       = 8,
  parameter int DECAY_TICKS = DEFAULT_DECAY_TICKS,
  parameter int DECAY_STEP  = DEFAULT_DECAY_STEP
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] pattern_in,
  input  logic                enable,
  output logic [CHANNELS-1:0] led_out,
  output logic                busy,
  output logic                decay_tick
);

  localparam int PRE_W = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DECAY_TICKS - 1);

  logic [CHANNELS-1:0] pattern_q;
  logic [PRE_W-1:0]    presc;
  logic [PWM_W-1:0]    pwm_cnt;
  logic [BRIGHT_W-1:0] bright [CHANNELS];

  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_q  <= '0;
      presc      <= '0;
      pwm_cnt    <= '0;
      decay_tick <= 1'b0;
    end else begin
      pattern_q  <= pattern_in;
      decay_tick <= enable && (presc == PRE_LAST);
      if (enable) begin
        presc   <= (presc == PRE_LAST) ? '0 : presc + 1'b1;
        pwm_cnt <= pwm_cnt + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    fade_channel #(
      .BRIGHT_W  (BRIGHT_W),
      .PWM_W     (PWM_W),
      .DECAY_STEP(DECAY_STEP)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .set       (pattern_q[i]),
      .decay_tick(decay_tick),
      .pwm_cnt   (pwm_cnt),
      .led       (led_out[i]),
      .bright    (bright[i])
    );
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < CHANNELS; i++)
      busy = busy | (|bright[i]);
  end

endmodule

// File: tb/tb_led_fader.sv
// tb/tb_led_fader.sv - randomized bench for led_fader against a cycle-level behavioural model
module tb_led_fader;

  localparam int DT   = 4;
  localparam int STEP = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pattern_in = 8'h00;
  logic       enable = 1'b1;
  logic [7:0] led_out;
  logic       busy;
  logic       decay_tick;

  logic [7:0] d_pattern = 8'h00;
  logic       d_rst = 1'b1;
  logic       d_enable = 1'b1;
  logic [7:0] d_led;
  logic       d_busy;
  logic       d_tick;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  led_fader #(.CHANNELS(8), .BRIGHT_W(8), .PWM_W(8), .DECAY_TICKS(DT), .DECAY_STEP(STEP)) u_dut (
    .clk(clk), .rst(rst), .pattern_in(pattern_in), .enable(enable),
    .led_out(led_out), .busy(busy), .decay_tick(decay_tick)
  );

  led_fader #(.CHANNELS(8), .BRIGHT_W(8), .PWM_W(8), .DECAY_TICKS(1000), .DECAY_STEP(128)) u_duty (
    .clk(clk), .rst(d_rst), .pattern_in(d_pattern), .enable(d_enable),
    .led_out(d_led), .busy(d_busy), .decay_tick(d_tick)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: integer brightness per LED, counters kept as plain modulo arithmetic.
  int       m_b [8];
  int       m_tick_pos;
  int       m_pwm;
  bit [7:0] m_pq;
  bit [7:0] m_led;
  bit       m_tick;
  bit       model_on = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      foreach (m_b[i]) m_b[i] = 0;
      m_tick_pos = 0; m_pwm = 0; m_pq = '0; m_led = '0; m_tick = 1'b0;
      model_on = 1'b1;
    end else if (model_on) begin
      for (int i = 0; i < 8; i++)
        m_led[i] = enable && (m_pq[i] || (m_pwm < m_b[i]));
      if (enable) begin
        for (int i = 0; i < 8; i++) begin
          if (m_pq[i])     m_b[i] = 255;
          else if (m_tick) m_b[i] = (m_b[i] > STEP) ? m_b[i] - STEP : 0;
        end
      end
      m_tick = enable && (m_tick_pos == DT - 1);
      if (enable) begin
        m_tick_pos = (m_tick_pos + 1) % DT;
        m_pwm      = (m_pwm + 1) % 256;
      end
      m_pq = pattern_in;
    end
  end

  function automatic bit model_busy();
    foreach (m_b[i]) if (m_b[i] != 0) return 1'b1;
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    if (model_on) begin
      check("led_out", 32'(led_out), 32'(m_led));
      check("busy", 32'(busy), 32'(model_busy()));
      check("decay_tick", 32'(decay_tick), 32'(m_tick));
      for (int i = 0; i < 8; i++)
        check($sformatf("bright%0d", i), 32'(u_dut.bright[i]), 32'(m_b[i]));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int hi;
    int waited;

    // Reset held with all bits requested; everything must stay dark.
    pattern_in = 8'hFF;
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(3);
    check("post_reset_led", 32'(led_out), 32'hFF);

    // Single pulse on bit 0 followed by a full fade.
    pattern_in = 8'h01; cyc(1);
    pattern_in = 8'h00; cyc(30);

    // Priority: bit 5 held through decay ticks.
    pattern_in = 8'h20; cyc(12);
    check("hold_bit5", 32'(u_dut.bright[5]), 32'd255);
    pattern_in = 8'h00; cyc(5);

    // Freeze mid-fade, then resume.
    pattern_in = 8'h04; cyc(1);
    pattern_in = 8'h00; cyc(6);
    enable = 1'b0; cyc(20);
    check("frozen_led", 32'(led_out), 32'h0);
    enable = 1'b1; cyc(20);

    // Walking one-hot with a reset dropped in the middle.
    for (int k = 0; k < 12; k++) begin
      pattern_in = 8'(1 << (k % 8));
      cyc(4);
      if (k == 9) begin
        rst = 1'b1; cyc(1);
        check("mid_reset_led", 32'(led_out), 32'h0);
        check("mid_reset_busy", 32'(busy), 32'h0);
        rst = 1'b0;
      end
    end

    // Random traffic: sparse patterns, occasional freeze and rare resets.
    for (int k = 0; k < 1500; k++) begin
      pattern_in = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      if ($urandom_range(0, 19) == 0) enable = ~enable;
      rst = ($urandom_range(0, 199) == 0);
      cyc(1);
    end
    rst = 1'b0; enable = 1'b1; pattern_in = 8'h00;
    cyc(40);
    check("final_busy", 32'(busy), 32'h0);

    // Duty-cycle check on the slow instance: b[3] = 255 - 128 = 127.
    d_rst = 1'b0;
    d_pattern = 8'h08; cyc(1);
    d_pattern = 8'h00;
    waited = 0;
    while (!d_tick && waited < 2000) begin cyc(1); waited++; end
    check("duty_tick_seen", 32'(d_tick), 32'h1);
    cyc(2);
    check("duty_bright", 32'(u_duty.bright[3]), 32'd127);
    hi = 0;
    for (int k = 0; k < 256; k++) begin
      if (d_led[3]) hi++;
      cyc(1);
    end
    check("duty_count", 32'(hi), 32'd127);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_fader.md
Name: led_fader

Overview:
Downstream consumer of the 8-bit rotating LED pattern driven onto gpio on the ECP3 Versa board. Each set pattern bit lights its LED fully. When a bit clears, that LED fades out through a per-channel brightness register and PWM, instead of switching off. The result is a decaying "comet tail" behind the walking bit. Sits between the pattern generator and the board LED pins, on the same clock.

Parameters:
CHANNELS, 8, number of LED channels (pattern width)
BRIGHT_W, 8, brightness register width per channel; max brightness = 2^BRIGHT_W-1
PWM_W, 8, PWM counter width; must satisfy PWM_W <= BRIGHT_W
DECAY_TICKS, 50000, clk cycles per decay step (prescaler period); must be >= 1
DECAY_STEP, 4, brightness decrement per decay tick; must satisfy 1 <= DECAY_STEP <= 2^BRIGHT_W-1

Ports:
clk  input  1  system clock, single clock domain
rst  input  1  reset, synchronous, active-high
pattern_in  input  CHANNELS  LED pattern from upstream stage, same clock domain
enable  input  1  1 = run; 0 = freeze fade state and blank outputs
led_out  output  CHANNELS  registered LED drive, 1 = on
busy  output  1  1 while any channel brightness is nonzero
decay_tick  output  1  one-cycle pulse each prescaler wrap

Behaviour:
- Clocking and reset: one clock (clk); reset rst is synchronous and active-high. All state is updated on the clk rising edge.
- Reset values: pattern_q=0, all b[i]=0, prescaler=0, pwm_cnt=0, led_out=0, decay_tick=0, busy=0. Reset mid-fade clears everything on the next edge; no residual glow.
- Input stage: pattern_q <= pattern_in every cycle, including when enable=0. No CDC logic.
- Prescaler:
  - Counts 0..DECAY_TICKS-1 and wraps to 0, only while enable=1.
  - decay_tick is registered and is 1 for exactly one cycle when the prescaler wraps. With DECAY_TICKS=1 it is 1 on every enabled cycle.
- PWM counter: pwm_cnt free-runs 0..2^PWM_W-1, wrapping, only while enable=1.
- Brightness update per channel i, only while enable=1, in priority order:
  1. pattern_q[i]=1: b[i] <= max.
  2. Else, on a decay tick: b[i] <= b[i]-DECAY_STEP when b[i] > DECAY_STEP, else 0 (saturate at 0, never wrap).
  3. Else: hold.
  - A set pattern bit beats a decay in the same cycle. Channels update independently and simultaneously.
- Output:
  - led_out[i] <= enable & (pattern_q[i] | (pwm_cnt < b[i][BRIGHT_W-1 -: PWM_W])).
  - A set bit gives solid on. During a fade, duty = top PWM_W bits of b / 2^PWM_W. b=0 gives solid off.
  - Latency pattern_in -> led_out: 2 cycles.
- enable=0:
  - Prescaler, pwm_cnt and b[] freeze; led_out=0 from the next edge; decay_tick=0.
  - On re-enable, counting and fading resume from the frozen values.
- busy = OR of all b[i], combinational from registers. Deasserts in the cycle after the last channel reaches 0.

Decomposition:
- Package led_pkg: BRIGHT_MAX constant function (2^BRIGHT_W-1), default DECAY_TICKS/DECAY_STEP values, and the saturating-decrement function.
- Sub-module fade_channel holds one brightness register, its update priority logic and its PWM compare. It takes pwm_cnt, decay_tick, enable and its pattern bit, and is generated CHANNELS times.
- Prescaler, pwm_cnt, input register and busy reduction live in the top.

Test Plan:
(Benches use DECAY_TICKS=4, DECAY_STEP=64, BRIGHT_W=PWM_W=8 unless stated.)
1. Reset: rst=1 for 3 cycles with pattern_in=8'hFF -> led_out=0, busy=0, decay_tick=0 throughout. After release, led_out=8'hFF two cycles later.
2. Fade sequence: pattern_in=8'h01 for one cycle, then 0 -> led_out[0]=1 two cycles later and b[0]=255. Successive decay ticks give b[0]=191, 127, 63, 0. busy drops the cycle after 0; led_out[0] then stays 0.
3. Duty: DECAY_TICKS=1000, DECAY_STEP=128; pulse bit 3, wait one decay tick -> b[3]=127. Over a full 256-cycle PWM window, led_out[3] is high exactly 127 cycles.
4. Priority: hold pattern bit 5 high across a decay_tick cycle -> b[5] stays 255 and led_out[5] stays 1. Same-cycle set on bit 6 and decay on bit 7 both apply.
5. Freeze: enable=0 at b[2]=127 for 20 cycles -> led_out=0, b[2] stays 127, no decay_tick. On re-enable, the next decay gives 63.
6. Walking pattern: drive rotating one-hot 01,02,04,…,80,01 every 4 cycles -> newest bit solid on and trailing channels at 255-64k. Assert rst mid-sequence -> all outputs 0 next cycle.
